msrv32_integer_file: RTL and testbench
======================================

Name: msrv32_integer_file

Overview:
Integer register file x0–x31 for the msrv32 core. It is the consumer end of the write-back enable path: it accepts the flush-gated integer write enable, destination address and write-back data from the WB stage. It supplies two source operands to the decode/execute stage, with same-cycle write-to-read bypass so that a write-back and a dependent read in the same cycle resolve without a stall.

Parameters:
- XLEN, 32, data width of each register and of every data port.
- RESET_VALUE, 32'h0000_0000, value loaded into x1–x31 on reset.

Ports:
- ms_riscv32_mp_clk_in, input, 1, core clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in, input, 1, asynchronous active-high reset.
- rs_1_addr_in, input, 5, source register 1 index.
- rs_2_addr_in, input, 5, source register 2 index.
- rd_addr_in, input, 5, destination register index from the WB stage.
- wr_en_in, input, 1, integer-file write enable, already flush-gated upstream.
- rd_in, input, XLEN, write-back data.
- rs_1_out, output, XLEN, operand for rs_1_addr_in.
- rs_2_out, output, XLEN, operand for rs_2_addr_in.

Behaviour:
- Storage: 31 physical XLEN-bit registers, x1–x31. x0 has no storage and always reads 0.
- Reset: while ms_riscv32_mp_rst_in=1, x1–x31 are forced to RESET_VALUE, asynchronously and immediately, independent of the clock.
  - Writes are ignored during reset.
  - Bypass is suppressed during reset, so rs_1_out and rs_2_out show stored values only (RESET_VALUE, or 0 for x0).
- Reset release: the first rising edge after deassertion behaves as a normal write edge.
- Write:
  - On a rising edge with rst=0, wr_en_in=1 and rd_addr_in≠0, register[rd_addr_in] ← rd_in.
  - A write to x0 is silently dropped; no storage changes.
  - With wr_en_in=0 nothing changes, regardless of rd_addr_in or rd_in.
- Read: combinational, zero-cycle latency from address to data. For each port p ∈ {1,2}:
  - If rs_p_addr_in=0, then rs_p_out=0.
  - Else if rst=0, wr_en_in=1 and rd_addr_in=rs_p_addr_in, then rs_p_out=rd_in (bypass of the write committing at the next edge).
  - Else rs_p_out=register[rs_p_addr_in].
- Both ports are independent. Both may address the same register, and both may bypass simultaneously.
- A read of x0 never bypasses, even with wr_en_in=1 and rd_addr_in=0.
- Only one write port exists, so no write-write conflict is possible.
- X-safety: rs_p_out must not go X for any defined address after reset, including x0.
- Write enable is honoured exactly as given. The file applies no extra flush gating and no flush input exists.

Test Plan:
- Reset clears:
  - Stimulus: write 32'hDEAD_BEEF to x5; assert rst for 1 ns between edges; read x5.
  - Required: x5 reads 32'h0 immediately, without waiting for a clock edge.
- Write/read basic:
  - Stimulus: write x1=32'h1234_5678 and x31=32'hFFFF_FFFF in successive cycles; on the following cycle read rs1=x1, rs2=x31.
  - Required: outputs are 32'h1234_5678 and 32'hFFFF_FFFF.
- x0 hardwire:
  - Stimulus: wr_en_in=1, rd_addr_in=0, rd_in=32'hA5A5_A5A5; same cycle and next cycle read rs1=rs2=x0.
  - Required: both outputs are 0 in both cycles.
- Bypass:
  - Stimulus: x7 holds 32'h0000_0011; in one cycle drive wr_en_in=1, rd_addr_in=7, rd_in=32'h0000_0022, rs_1_addr_in=7, rs_2_addr_in=7.
  - Required: both outputs are 32'h22 before the edge, and remain 32'h22 after the edge with wr_en_in=0.
- Gated write:
  - Stimulus: wr_en_in=0, rd_addr_in=3, rd_in=32'h0BAD_0BAD; read x3.
  - Required: x3 keeps its prior value (0 after reset) and no bypass occurs.
- Reset mid-write:
  - Stimulus: wr_en_in=1, rd_addr_in=9, rd_in=32'h99; rst asserted across the rising edge.
  - Required: x9 reads 0 during and after reset, and rs outputs show 0, not 32'h99.

Source files
------------

// File: rtl/msrv32_integer_file.sv
// Integer register file x0-x31 with two combinational read ports and one write port.
// Same-cycle write-to-read bypass lets a dependent read see the value being written back.
module msrv32_integer_file #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_VALUE = '0
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic [4:0]       rs_1_addr_in,
  input  logic [4:0]       rs_2_addr_in,
  input  logic [4:0]       rd_addr_in,
  input  logic             wr_en_in,
  input  logic [XLEN-1:0]  rd_in,
  output logic [XLEN-1:0]  rs_1_out,
  output logic [XLEN-1:0]  rs_2_out
);

  // x0 has no storage; only x1-x31 are physical registers.
  logic [XLEN-1:0] regs_q [31:1];
  logic [XLEN-1:0] regs_d [31:1];

  logic write_ok;
  assign write_ok = wr_en_in && (rd_addr_in != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (write_ok) begin
      regs_d[rd_addr_in] = rd_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is held off during reset so the ports show only stored contents.
  logic bypass_ok;
  assign bypass_ok = write_ok && !ms_riscv32_mp_rst_in;

  always_comb begin
    rs_1_out = '0;
    if (rs_1_addr_in != 5'd0) begin
      if (bypass_ok && (rd_addr_in == rs_1_addr_in)) begin
        rs_1_out = rd_in;
      end else begin
        rs_1_out = regs_q[rs_1_addr_in];
      end
    end
  end

  always_comb begin
    rs_2_out = '0;
    if (rs_2_addr_in != 5'd0) begin
      if (bypass_ok && (rd_addr_in == rs_2_addr_in)) begin
        rs_2_out = rd_in;
      end else begin
        rs_2_out = regs_q[rs_2_addr_in];
      end
    end
  end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed self-checking bench for msrv32_integer_file: reset, writes, x0, bypass, gating.
module tb_msrv32_integer_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_1_addr;
  logic [4:0]  rs_2_addr;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [31:0] rd_data;
  logic [31:0] rs_1_data;
  logic [31:0] rs_2_data;

  int checks = 0;
  int errors = 0;

  msrv32_integer_file #(
    .XLEN        (32),
    .RESET_VALUE (32'h0000_0000)
  ) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .rs_1_addr_in         (rs_1_addr),
    .rs_2_addr_in         (rs_2_addr),
    .rd_addr_in           (rd_addr),
    .wr_en_in             (wr_en),
    .rd_in                (rd_data),
    .rs_1_out             (rs_1_data),
    .rs_2_out             (rs_2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after an edge and settle 1 ns before outputs are sampled.
  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    wr_en     = we;
    rd_addr   = rd;
    rd_data   = data;
    rs_1_addr = rs1;
    rs_2_addr = rs2;
    #1;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    checkOutput("reset_x1", rs_1_data, 32'h0);
    checkOutput("reset_x31", rs_2_data, 32'h0);
    stepEdge();
    rst = 1'b0;

    // Reset clears x5 immediately, without a clock edge
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    checkOutput("x5_bypass", rs_1_data, 32'hDEAD_BEEF);
    stepEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    checkOutput("x5_written", rs_1_data, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    checkOutput("x5_async_clear", rs_1_data, 32'h0);
    checkOutput("x5_async_clear_p2", rs_2_data, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("x5_after_pulse", rs_1_data, 32'h0);
    stepEdge();

    // Basic writes to x1 and x31
    applyStimulus(1'b1, 5'd1, 32'h1234_5678, 5'd0, 5'd0);
    stepEdge();
    applyStimulus(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd0, 5'd0);
    stepEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    checkOutput("rd_x1", rs_1_data, 32'h1234_5678);
    checkOutput("rd_x31", rs_2_data, 32'hFFFF_FFFF);

    // x0 never stores and never bypasses
    applyStimulus(1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0);
    checkOutput("x0_same_p1", rs_1_data, 32'h0);
    checkOutput("x0_same_p2", rs_2_data, 32'h0);
    stepEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
    checkOutput("x0_next_p1", rs_1_data, 32'h0);
    checkOutput("x1_untouched", rs_2_data, 32'h1234_5678);

    // Dual-port bypass on x7
    applyStimulus(1'b1, 5'd7, 32'h0000_0011, 5'd0, 5'd0);
    stepEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkOutput("x7_old", rs_1_data, 32'h0000_0011);
    applyStimulus(1'b1, 5'd7, 32'h0000_0022, 5'd7, 5'd7);
    checkOutput("x7_byp_p1", rs_1_data, 32'h0000_0022);
    checkOutput("x7_byp_p2", rs_2_data, 32'h0000_0022);
    stepEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checkOutput("x7_after_p1", rs_1_data, 32'h0000_0022);
    checkOutput("x7_after_p2", rs_2_data, 32'h0000_0022);

    // Ports are independent: one bypasses while the other reads storage
    applyStimulus(1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd1);
    checkOutput("indep_byp", rs_1_data, 32'h0000_0044);
    checkOutput("indep_store", rs_2_data, 32'h1234_5678);
    stepEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd4);
    checkOutput("indep_x4", rs_2_data, 32'h0000_0044);

    // Gated write leaves x3 alone and does not bypass
    applyStimulus(1'b0, 5'd3, 32'h0BAD_0BAD, 5'd3, 5'd3);
    checkOutput("gated_nobyp", rs_1_data, 32'h0);
    stepEdge();
    checkOutput("gated_x3", rs_2_data, 32'h0);

    // Reset held across a write edge
    applyStimulus(1'b1, 5'd9, 32'h0000_0099, 5'd9, 5'd9);
    checkOutput("x9_byp_pre", rs_1_data, 32'h0000_0099);
    rst = 1'b1;
    #1;
    checkOutput("x9_rst_p1", rs_1_data, 32'h0);
    checkOutput("x9_rst_p2", rs_2_data, 32'h0);
    stepEdge();
    checkOutput("x9_rst_edge", rs_1_data, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
    rst = 1'b0;
    #1;
    checkOutput("x9_after_rst", rs_1_data, 32'h0);
    checkOutput("x7_cleared", rs_2_data, 32'h0);

    // First edge after release is a normal write edge
    applyStimulus(1'b1, 5'd9, 32'h0000_0123, 5'd0, 5'd0);
    stepEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    checkOutput("x9_post_release", rs_1_data, 32'h0000_0123);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
